// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command engine.
// Latency: none (package).
// Backpressure: none (package).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    GET_OP = 3'd1,
    GET_A  = 3'd2,
    GET_B  = 3'd3,
    GET_CK = 3'd4,
    EXEC   = 3'd5,
    SEND   = 3'd6
  } state_t;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_BADCK = 8'h01;
  localparam logic [7:0] ST_BADOP = 8'h02;

  // Response frame: header, status, result high, result low, checksum
  localparam int RSP_LEN = 5;

endpackage

// File: rtl/uart_cmd_engine_alu.sv
// Command ALU: checks the frame checksum and evaluates the 8-bit opcode.
// Latency: combinational.
// Backpressure: none; the caller samples the outputs while in EXEC.
module cmd_alu
  import uart_cmd_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  ck,
  output logic [7:0]  status,
  output logic [15:0] result
);

  logic [15:0] a16;
  logic [15:0] b16;

  assign a16 = {8'h00, a};
  assign b16 = {8'h00, b};

  // A bad checksum takes priority over the opcode decode; errors return zero
  always_comb begin
    status = ST_OK;
    result = 16'h0000;
    if (ck != (op ^ a ^ b)) begin
      status = ST_BADCK;
    end else begin
      case (op)
        OP_ADD:  result = a16 + b16;
        OP_SUB:  result = a16 - b16;
        OP_MUL:  result = a16 * b16;
        OP_XOR:  result = {8'h00, a ^ b};
        default: status = ST_BADOP;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_engine.sv
// Frame command engine: hunts 5-byte command frames from the RX FIFO, answers with 5-byte response frames.
// Latency: 2 cycles from the CK byte pop to the first TX push (EXEC, then SEND).
// Backpressure: pops only when rx_empty=0, pushes only when tx_full=0, at most one byte every 2 cycles.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int         DBITS          = 8,
  parameter logic [7:0] HDR_CMD        = 8'hA5,
  parameter logic [7:0] HDR_RSP        = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         TO_BITS        = 20
) (
  input  logic             clk_100MHz,
  input  logic             reset_btn,
  input  logic             rx_empty,
  input  logic [DBITS-1:0] read_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBITS-1:0] write_data,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt
);

  state_t                   state;
  logic [DBITS-1:0]         op;
  logic [DBITS-1:0]         a;
  logic [DBITS-1:0]         b;
  logic [DBITS-1:0]         ck;
  logic [RSP_LEN*DBITS-1:0] rsp_buf;
  logic [2:0]               tx_idx;
  logic [7:0]               alu_status;
  logic [15:0]              alu_result;
  logic                     rx_pop;
  logic                     tx_push;

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
  logic [TO_BITS-1:0] to_cnt;
`endif

  // The rd_uart/wr_uart terms keep a strobe from repeating before the FIFO flag catches up
  assign rx_pop  = (state inside {HUNT, GET_OP, GET_A, GET_B, GET_CK}) && !rx_empty && !rd_uart;
  assign tx_push = (state == SEND) && !tx_full && !wr_uart;

  cmd_alu u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .ck     (ck),
    .status (alu_status),
    .result (alu_result)
  );

  // Frame FSM with registered FIFO strobes, status counters and optional timeout
  always_ff @(posedge clk_100MHz or posedge reset_btn) begin
    if (reset_btn) begin
      state      <= HUNT;
      rd_uart    <= 1'b0;
      wr_uart    <= 1'b0;
      write_data <= '0;
      busy       <= 1'b0;
      frame_cnt  <= 8'h00;
      err_cnt    <= 8'h00;
      op         <= '0;
      a          <= '0;
      b          <= '0;
      ck         <= '0;
      rsp_buf    <= '0;
      tx_idx     <= 3'd0;
`ifdef UART_CMD_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_pop) begin
            rd_uart <= 1'b1;
            if (read_data == HDR_CMD) begin
              state <= GET_OP;
              busy  <= 1'b1;
            end
          end
        end
        GET_OP: begin
          if (rx_pop) begin
            rd_uart <= 1'b1;
            op      <= read_data;
            state   <= GET_A;
          end
        end
        GET_A: begin
          if (rx_pop) begin
            rd_uart <= 1'b1;
            a       <= read_data;
            state   <= GET_B;
          end
        end
        GET_B: begin
          if (rx_pop) begin
            rd_uart <= 1'b1;
            b       <= read_data;
            state   <= GET_CK;
          end
        end
        GET_CK: begin
          if (rx_pop) begin
            rd_uart <= 1'b1;
            ck      <= read_data;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_buf <= {HDR_RSP, alu_status, alu_result[15:8], alu_result[7:0],
                      alu_status ^ alu_result[15:8] ^ alu_result[7:0]};
          tx_idx  <= 3'd0;
          if (alu_status == ST_OK) frame_cnt <= frame_cnt + 8'd1;
          else                     err_cnt   <= err_cnt + 8'd1;
          state   <= SEND;
        end
        SEND: begin
          if (tx_push) begin
            wr_uart    <= 1'b1;
            write_data <= rsp_buf[RSP_LEN*DBITS-1 -: DBITS];
            rsp_buf    <= rsp_buf << DBITS;
            if (tx_idx == 3'(RSP_LEN - 1)) begin
              state <= HUNT;
              busy  <= 1'b0;
            end else begin
              tx_idx <= tx_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      // A stalled partial frame is abandoned silently and counted as an error
      if (state inside {GET_OP, GET_A, GET_B, GET_CK}) begin
        if (rx_pop) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
          to_cnt  <= '0;
          state   <= HUNT;
          busy    <= 1'b0;
          err_cnt <= err_cnt + 8'd1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
Frame-level command processor that replaces the button-driven debug loop. It sits between the uart_top RX FIFO and TX FIFO ports.
- Pops bytes from the RX FIFO and hunts for a 5-byte command frame.
- Validates the checksum, executes an 8-bit arithmetic opcode, and pushes a 5-byte response frame into the TX FIFO.
- Provides a fully autonomous echo/compute path for host-side testing.

Parameters:
- DBITS, 8, data word width; fixed at 8 for this frame format.
- HDR_CMD, 8'hA5, command frame header byte.
- HDR_RSP, 8'h5A, response frame header byte.
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clk cycles; used only with UART_CMD_TIMEOUT_EN.
- TO_BITS, 20, timeout counter width.

Ports:
- clk_100MHz  in  1  system clock
- reset_btn  in  1  asynchronous, active-high reset
- rx_empty  in  1  RX FIFO empty flag
- read_data  in  8  RX FIFO head word; first-word-fall-through, valid while rx_empty=0
- rd_uart  out  1  RX FIFO pop strobe; one cycle per byte
- tx_full  in  1  TX FIFO full flag
- wr_uart  out  1  TX FIFO push strobe; one cycle per byte
- write_data  out  8  byte pushed with wr_uart
- busy  out  1  high in any state other than HUNT
- frame_cnt  out  8  count of executed frames (status 0x00), wraps at 255
- err_cnt  out  8  count of error responses (status != 0), wraps at 255

Behaviour:
- Reset (async, active-high) forces:
  - state = HUNT
  - rd_uart=0, wr_uart=0, write_data=0, busy=0, frame_cnt=0, err_cnt=0
  - all operand registers = 0
- Reset asserted mid-frame or mid-response discards the partial frame. No further TX bytes are pushed.
- All outputs are registered.
- RX pop rule:
  - In a receive state with rx_empty=0 and rd_uart=0: assert rd_uart for one cycle and latch read_data in the same cycle.
  - rd_uart is never high two consecutive cycles, which guards the one-cycle empty-flag lag.
  - Maximum RX rate is one byte per 2 cycles.
- States:
  - HUNT: pop bytes; byte==HDR_CMD -> GET_OP; any other byte is discarded, stay in HUNT.
  - GET_OP -> GET_A -> GET_B -> GET_CK: one popped byte each, latched into op, a, b, ck.
  - EXEC: one cycle; computes status and result; loads response shift buffer; -> SEND.
  - SEND: push 5 bytes in order: HDR_RSP, status, res[15:8], res[7:0], rsp_ck. After the 5th push -> HUNT.
- Checksum rules:
  - Command valid iff ck == op^a^b.
  - rsp_ck = status^res[15:8]^res[7:0].
- Status and result:
  - Checksum mismatch: status 0x01, result 0x0000.
  - Otherwise, by opcode (8-bit operands zero-extended to 16 bits):
    - 0x01 ADD: a+b
    - 0x02 SUB: a-b, 16-bit two's complement (wraps)
    - 0x03 MUL: a*b
    - 0x04 XOR: {8'h00, a^b}
    - Any other opcode: status 0x02, result 0x0000.
  - Status 0x00 means success.
- Counters: frame_cnt increments in EXEC when status==0x00. err_cnt increments in EXEC when status!=0x00.
- TX push rule:
  - In SEND with tx_full=0 and wr_uart=0: assert wr_uart with write_data set in the same registered update.
  - While tx_full=1, hold the byte index; no byte is dropped or duplicated.
  - Maximum TX rate is one byte per 2 cycles.
- No RX pops occur during EXEC or SEND. Incoming bytes accumulate in the RX FIFO.
- Latency: from the pop of the CK byte to the first wr_uart is 2 cycles (EXEC, then the SEND push) when tx_full=0.

Optional Feature:
UART_CMD_TIMEOUT_EN
- Defined:
  - In GET_OP..GET_CK, a counter clears on every pop and increments otherwise.
  - On reaching TIMEOUT_CYCLES-1: return to HUNT, increment err_cnt, send no response.
- Undefined: no timeout logic; a partial frame waits indefinitely.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (HUNT, GET_OP, GET_A, GET_B, GET_CK, EXEC, SEND)
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_XOR
  - status constants ST_OK=0x00, ST_BADCK=0x01, ST_BADOP=0x02
  - response length 5
- Sub-module cmd_alu: combinational; inputs op, a, b, ck; outputs status[7:0], result[15:0].
- The FSM, FIFO handshakes, counters and timeout stay in uart_cmd_engine.

Test Plan:
- ADD: RX A5 01 12 34 27 -> TX 5A 00 00 46 46; frame_cnt=1.
- MUL and SUB:
  - A5 03 FF FF 03 -> TX 5A 00 FE 01 FF.
  - A5 02 01 02 01 -> TX 5A 00 FF FF 00.
- Errors:
  - Bad checksum A5 01 12 34 00 -> TX 5A 01 00 00 01.
  - Unknown opcode A5 07 01 01 07 -> TX 5A 02 00 00 02.
  - After both: err_cnt=2, frame_cnt unchanged.
- Resync: RX 00 FF 33 then A5 04 0F F0 FB -> garbage ignored; TX 5A 00 00 FF FF.
- Backpressure: hold tx_full=1 for 50 cycles during SEND after byte 2 -> wr_uart stays 0 while tx_full=1; remaining bytes resume in order, exactly 5 pushes total.
- Reset mid-frame and timeout:
  - reset_btn pulse after A5 01 -> all outputs 0, next full frame answered correctly.
  - With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: A5 01 then 100 idle cycles -> HUNT, err_cnt=1, no TX.
